// File: rtl/seq_alu_pkg.sv
// -----------------------------------------------------------------------------
// seq_alu_pkg
// Shared definitions for the sequential ALU:
//   - OPC_W          : opcode width
//   - OP_*           : opcode values (legacy 0-7, shifts 8-10, multiply 11)
//   - state_t, ST_*  : FSM state encoding
//   - op_is_legal()  : opcode legality, which depends on the build
// Build option: SEQ_ALU_MUL_EN enables the iterative multiply (opcode 11).
// -----------------------------------------------------------------------------
package seq_alu_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_AND = 4'd0;
    localparam logic [OPC_W-1:0] OP_OR  = 4'd1;
    localparam logic [OPC_W-1:0] OP_XOR = 4'd2;
    localparam logic [OPC_W-1:0] OP_NOR = 4'd3;
    localparam logic [OPC_W-1:0] OP_SLT = 4'd4;
    localparam logic [OPC_W-1:0] OP_ADD = 4'd5;
    localparam logic [OPC_W-1:0] OP_SUB = 4'd6;
    localparam logic [OPC_W-1:0] OP_MOV = 4'd7;
    localparam logic [OPC_W-1:0] OP_SLL = 4'd8;
    localparam logic [OPC_W-1:0] OP_SRL = 4'd9;
    localparam logic [OPC_W-1:0] OP_SRA = 4'd10;
    localparam logic [OPC_W-1:0] OP_MUL = 4'd11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Opcodes 0-10 always exist; 11 only when the multiplier is built in.
    function automatic logic op_is_legal(input logic [OPC_W-1:0] op);
`ifdef SEQ_ALU_MUL_EN
        return (op <= OP_MUL);
`else
        return (op <= OP_SRA);
`endif
    endfunction

endpackage

// File: rtl/seq_alu_comb.sv
// -----------------------------------------------------------------------------
// seq_alu_comb
// Purely combinational datapath for the single-cycle opcodes 0-10.
// Opcodes outside that range produce result 0 and no overflow; legality is
// decided by the caller.
// Ports:
//   i_op     [OPC_W-1:0]  operation code
//   i_a      [WIDTH-1:0]  operand A
//   i_b      [WIDTH-1:0]  operand B (low SHW bits are the shift amount)
//   o_result [WIDTH-1:0]  operation result
//   o_ovf                 signed overflow, ADD/SUB only
// -----------------------------------------------------------------------------
module seq_alu_comb
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [OPC_W-1:0] i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_ovf
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [SHW-1:0]   w_shamt;
    logic             w_sa;
    logic             w_sb;

    assign w_sum   = i_a + i_b;
    assign w_diff  = i_a - i_b;
    assign w_shamt = i_b[SHW-1:0];
    assign w_sa    = i_a[WIDTH-1];
    assign w_sb    = i_b[WIDTH-1];

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        o_result = '0;
        o_ovf    = 1'b0;
        case (i_op)
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_XOR: o_result = i_a ^ i_b;
            OP_NOR: o_result = ~(i_a | i_b);
            OP_SLT: o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_ADD: begin
                o_result = w_sum;
                // Same-sign operands whose sum flips sign.
                o_ovf    = (w_sa == w_sb) && (w_sum[WIDTH-1] != w_sa);
            end
            OP_SUB: begin
                o_result = w_diff;
                // Opposite-sign operands whose difference takes B's sign.
                o_ovf    = (w_sa != w_sb) && (w_diff[WIDTH-1] != w_sa);
            end
            OP_MOV: o_result = i_a;
            OP_SLL: o_result = i_a << w_shamt;
            OP_SRL: o_result = i_a >> w_shamt;
            OP_SRA: o_result = $unsigned($signed(i_a) >>> w_shamt);
            default: begin
                o_result = '0;
                o_ovf    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Handshaked ALU with a registered result. Single-cycle ops complete one clock
// after acceptance; MUL (when built) iterates a shift-add multiplier with early
// exit once the remaining multiplier bits are all zero.
// Build option: SEQ_ALU_MUL_EN enables opcode 11; without it the FSM is
// IDLE/DONE only and opcode 11 is reported as illegal.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   request handshake (in_ready only in IDLE)
//   alu_ctr               opcode
//   alu_src1 / alu_src2   operands A / B
//   out_valid / out_ready result handshake (out_valid only in DONE)
//   alu_result            registered result, held stable in DONE
//   zero_bit              alu_result == 0
//   ovf_bit               signed overflow for ADD/SUB
//   err_bit               illegal or disabled opcode
// -----------------------------------------------------------------------------
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPC_W-1:0] alu_ctr,
    input  logic [WIDTH-1:0] alu_src1,
    input  logic [WIDTH-1:0] alu_src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_bit,
    output logic             ovf_bit,
    output logic             err_bit
);

    state_t           r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_ovf;
    logic             r_err;

    logic [WIDTH-1:0] w_comb_result;
    logic             w_comb_ovf;
    logic             w_legal;
    logic             w_start_mul;

    seq_alu_comb #(
        .WIDTH    (WIDTH)
    ) u_comb (
        .i_op     (alu_ctr),
        .i_a      (alu_src1),
        .i_b      (alu_src2),
        .o_result (w_comb_result),
        .o_ovf    (w_comb_ovf)
    );

    assign w_legal = op_is_legal(alu_ctr);

`ifdef SEQ_ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_mplier_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_mul_last;

    assign w_start_mul   = (alu_ctr == OP_MUL);
    assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplier_next = r_mplier >> 1;
    assign w_cnt_next    = r_cnt + 1'b1;
    // Remaining multiplier bits all zero means the product is already final.
    assign w_mul_last    = (w_mplier_next == '0) || (w_cnt_next == CNT_W'(WIDTH));
`else
    assign w_start_mul   = 1'b0;
`endif

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // blocking assignments would make the update order simulation-dependent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (w_start_mul) begin
`ifdef SEQ_ALU_MUL_EN
                            r_mcand  <= alu_src1;
                            r_mplier <= alu_src2;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_state  <= ST_BUSY;
`endif
                        end else if (!w_legal) begin
                            r_result <= '0;
                            r_ovf    <= 1'b0;
                            r_err    <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_result <= w_comb_result;
                            r_ovf    <= w_comb_ovf;
                            r_err    <= 1'b0;
                            r_state  <= ST_DONE;
                        end
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                ST_BUSY: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= w_cnt_next;
                    if (w_mul_last) begin
                        // Take this cycle's partial sum directly, not r_acc.
                        r_result <= w_acc_next;
                        r_ovf    <= 1'b0;
                        r_err    <= 1'b0;
                        r_state  <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = (r_state == ST_DONE);
    assign alu_result = r_result;
    assign zero_bit   = (r_result == '0);
    assign ovf_bit    = r_ovf;
    assign err_bit    = r_err;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
// Directed and randomised stimulus for seq_alu (WIDTH=32). Expected values come
// from an arithmetic reference model; MUL expectations are only built when
// SEQ_ALU_MUL_EN is defined, otherwise opcode 11 is expected to be illegal.
// -----------------------------------------------------------------------------
module tb_seq_alu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_ctr;
    logic [W-1:0] alu_src1;
    logic [W-1:0] alu_src2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_result;
    logic         zero_bit;
    logic         ovf_bit;
    logic         err_bit;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_ctr    (alu_ctr),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .zero_bit   (zero_bit),
        .ovf_bit    (ovf_bit),
        .err_bit    (err_bit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: results from plain arithmetic on wide signed values.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic ovf, output logic err,
                         output int lat);
        longint sa;
        longint sb;
        longint s;
        int     sh;
        logic [63:0] p;
        int     msb;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sh  = int'(b % W);
        r   = '0;
        ovf = 1'b0;
        err = 1'b0;
        lat = 1;
        p   = '0;
        msb = -1;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a ^ b;
            4'd3: r = ~(a | b);
            4'd4: r = (sa < sb) ? 1 : 0;
            4'd5: begin
                s   = sa + sb;
                r   = W'(s);
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd6: begin
                s   = sa - sb;
                r   = W'(s);
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd7: r = a;
            4'd8: r = a << sh;
            4'd9: r = a >> sh;
            4'd10: r = W'(sa >>> sh);
`ifdef SEQ_ALU_MUL_EN
            4'd11: begin
                p = {32'd0, a} * {32'd0, b};
                r = p[W-1:0];
                for (int i = 0; i < W; i++) if (b[i]) msb = i;
                // One iteration per multiplier bit up to the top set bit
                // (at least one), plus the acceptance cycle.
                lat = ((msb < 0) ? 1 : msb + 1) + 1;
            end
`endif
            default: err = 1'b1;
        endcase
    endtask

    // Issues one operation and checks latency, result and flags. When release
    // is set, also completes the output handshake and checks the return to IDLE.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit release_out);
        logic [W-1:0] er;
        logic         eovf;
        logic         eerr;
        int           elat;
        int           lat;
        model(op, a, b, er, eovf, eerr, elat);
        check({tag, ".ready_before"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        alu_ctr  = op;
        alu_src1 = a;
        alu_src2 = b;
        tick();
        in_valid = 1'b0;
        check({tag, ".ready_after_accept"}, 64'(in_ready), 64'd0);
        lat = 1;
        while (!out_valid && lat < W + 4) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(elat));
        check({tag, ".result"}, 64'(alu_result), 64'(er));
        check({tag, ".zero"}, 64'(zero_bit), 64'(er == '0));
        check({tag, ".ovf"}, 64'(ovf_bit), 64'(eovf));
        check({tag, ".err"}, 64'(err_bit), 64'(eerr));
        if (release_out) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check({tag, ".idle_ready"}, 64'(in_ready), 64'd1);
            check({tag, ".idle_valid"}, 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        logic [3:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_ctr   = '0;
        alu_src1  = '0;
        alu_src2  = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.zero", 64'(zero_bit), 64'd1);
        check("reset.result", 64'(alu_result), 64'd0);
        check("reset.ovf", 64'(ovf_bit), 64'd0);
        check("reset.err", 64'(err_bit), 64'd0);

        // Directed boundaries.
        do_op("add_ovf", 4'd5, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
        do_op("sub_zero", 4'd6, 32'd5, 32'd5, 1'b1);
        do_op("sub_ovf", 4'd6, 32'h8000_0000, 32'd1, 1'b1);
        do_op("slt_minneg", 4'd4, 32'h8000_0000, 32'd0, 1'b1);
        do_op("sra", 4'd10, 32'hF000_0000, 32'h0000_0024, 1'b1);
        do_op("sll", 4'd8, 32'd1, 32'd31, 1'b1);
        do_op("srl", 4'd9, 32'h8000_0000, 32'hFFFF_FFE4, 1'b1);
        do_op("nor", 4'd3, 32'h0F0F_0F0F, 32'hF0F0_0000, 1'b1);
        do_op("illegal13", 4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        do_op("op11", 4'd11, 32'h0000_FFFF, 32'h0001_0001, 1'b1);
        do_op("op11_b0", 4'd11, 32'd7, 32'd0, 1'b1);
        do_op("mul_full", 4'd11, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1);

        // DONE holds its result while in_valid and a new request are ignored.
        do_op("hold", 4'd5, 32'd10, 32'd20, 1'b0);
        in_valid = 1'b1;
        alu_ctr  = 4'd6;
        alu_src1 = 32'd1;
        alu_src2 = 32'd100;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold.result", 64'(alu_result), 64'd30);
            check("hold.valid", 64'(out_valid), 64'd1);
            check("hold.ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold.idle_ready", 64'(in_ready), 64'd1);
        check("hold.idle_valid", 64'(out_valid), 64'd0);
        check("hold.result_kept", 64'(alu_result), 64'd30);

        // out_ready while IDLE must not disturb anything.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_out_ready.ready", 64'(in_ready), 64'd1);

        // Asynchronous reset while the block is occupied.
`ifdef SEQ_ALU_MUL_EN
        in_valid = 1'b1;
        alu_ctr  = 4'd11;
        alu_src1 = 32'h0000_FFFF;
        alu_src2 = 32'h0001_0001;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("midmul.busy_ready", 64'(in_ready), 64'd0);
        check("midmul.busy_valid", 64'(out_valid), 64'd0);
`else
        do_op("prereset", 4'd13, 32'd7, 32'd8, 1'b0);
`endif
        reset = 1'b1;
        #1;
        check("async_reset.in_ready", 64'(in_ready), 64'd1);
        check("async_reset.out_valid", 64'(out_valid), 64'd0);
        check("async_reset.result", 64'(alu_result), 64'd0);
        check("async_reset.zero", 64'(zero_bit), 64'd1);
        check("async_reset.err", 64'(err_bit), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        do_op("add_after_reset", 4'd5, 32'd2, 32'd3, 1'b1);

        // Randomised mix over all 16 opcodes with corner-biased operands.
        for (int n = 0; n < 40; n++) begin
            rop = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: ra = 32'h8000_0000;
                1: ra = 32'h7FFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: rb = 32'h0000_0000;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(0, 255));
                default: rb = $urandom;
            endcase
            do_op("rand", rop, ra, rb, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
